krnl_msm_rd_sched: RTL and testbench
====================================

# krnl_msm_rd_sched

AXI4 read-address scheduler for one DDR read port of the MSM kernel. It accepts a linear fetch command (base address, beat count) from the kernel core. It splits the command into INCR bursts that never cross a 4 KB boundary, and issues them on the port's AR channel, keeping at most C_MAX_OUTSTANDING bursts in flight. It signals completion when every burst's last R beat has been consumed. One instance sits in front of each axi_m_N read channel inside krnl_msm_381_core; the R data path bypasses it, and only last-beat handshakes are fed back.

## Interface
- C_AXI_M_ADDR_W, 64, AXI address width
- C_AXI_M_DATA_W, 512, AXI data width; beat size = C_AXI_M_DATA_W/8 bytes
- C_LEN_W, 32, width of beat-count command field
- C_MAX_BURST, 64, max beats per burst (power of 2, ≤256, beat bytes × C_MAX_BURST ≤ 4096)
- C_MAX_OUTSTANDING, 16, max bursts issued but not yet completed (≥1)

Ports:
- ap_clk  in  1  sole clock
- ap_rst_n  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when both high
- cmd_addr  in  C_AXI_M_ADDR_W  byte base address; low log2(beat bytes) bits ignored (treated as 0)
- cmd_beats  in  C_LEN_W  total beats; 0 = null command
- busy  out  1  high from command accept until done
- done  out  1  one-cycle completion pulse
- axi_ARVALID  out  1  AR valid
- axi_ARREADY  in  1  AR ready
- axi_ARADDR  out  C_AXI_M_ADDR_W  burst address
- axi_ARLEN  out  8  beats-1
- axi_ARSIZE  out  3  constant log2(beat bytes)
- r_last_hs  in  1  pulse: an R beat with RLAST was accepted by the consumer this cycle

## Operation
- FSM states: IDLE, ISSUE, DRAIN.
- IDLE: cmd_ready=1. On accept with cmd_beats=0, stay IDLE and pulse done next cycle. Otherwise latch addr and remaining=cmd_beats, set busy, go ISSUE.
- Burst length: len = min(remaining, C_MAX_BURST, 4096/beat_bytes − addr[11:log2(beat_bytes)]). It is computed from registered addr/remaining. ARLEN=len−1.
- ISSUE: raise ARVALID only when outstanding < C_MAX_OUTSTANDING. Once raised, ARVALID/ARADDR/ARLEN stay stable until ARREADY.
- On AR handshake: addr += len×beat_bytes, remaining −= len, outstanding += 1.
  - If remaining becomes 0, drop ARVALID and go DRAIN.
  - Otherwise present the next burst in the following cycle, provided the credit check passes.
- DRAIN: when outstanding reaches 0, go IDLE, clear busy, pulse done.
- Outstanding counter: +1 on AR handshake, −1 on r_last_hs. When both occur in the same cycle, the count is unchanged. r_last_hs with outstanding=0 is ignored (no underflow).
- Credit check uses the registered count, so freed credit takes effect one cycle after r_last_hs.
- Address arithmetic wraps modulo 2^C_AXI_M_ADDR_W. No error is flagged; software must not request a wrap.

## Timing
- Reset values: cmd_ready=0 during reset, then 1 in IDLE. busy=0, done=0, axi_ARVALID=0, axi_ARADDR=0, axi_ARLEN=0. axi_ARSIZE is constant. Outstanding count=0.
- First ARVALID appears the cycle after command accept.
- Sustained issue rate: 1 burst/cycle while ARREADY=1 and credits remain.
- done is registered and high exactly one cycle: the cycle after the final r_last_hs is sampled. cmd_ready is high in that same cycle.
- All outputs are registered. There is no combinational path from axi_ARREADY or r_last_hs to any output.
- Reset mid-operation returns to IDLE immediately and discards in-flight state. The interconnect must be reset alongside this block.

## Structure
- Package krnl_msm_pkg holds:
  - the state enum;
  - C_AXI_4K_BYTES=4096;
  - a function returning ARSIZE from the data width;
  - beat-byte and 4 KB-beat constants.
- One combinational sub-module, krnl_msm_burst_split, takes (addr, remaining) and returns len. It is reused by future write-side schedulers.

## Test plan
- Single beat, addr 0x1000, beats 1:
  - one AR (0x1000, ARLEN 0, ARSIZE 6);
  - r_last_hs 3 cycles later → done exactly 1 cycle after it, busy falls with it.
- 4 KB crossing, addr 0x0FC0, beats 4 → ARs (0x0FC0, ARLEN 0) then (0x1000, ARLEN 2).
- Long fetch, addr 0, beats 200, ARREADY=1 → ARLEN 63, 63, 63, 7 on consecutive cycles at 0x0, 0x1000, 0x2000, 0x3000.
- Credit limit: beats 2048, r_last_hs withheld → exactly 16 ARs, then ARVALID low. One r_last_hs → exactly one more AR, issued 2 cycles later.
- ARREADY backpressure:
  - ARREADY low for 5 cycles → ARADDR/ARLEN/ARVALID stable throughout.
  - r_last_hs coincident with AR handshake → count unchanged.
- Zero-beat command → no AR, done 1 cycle after accept.
- Reset asserted mid-ISSUE → ARVALID, busy and done go 0 asynchronously; a new command then starts cleanly.

Source files
------------

// File: rtl/krnl_msm_pkg.sv
// Shared types and constants for the MSM kernel AXI read/write schedulers.
package krnl_msm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN
  } state_e;

  localparam int unsigned C_AXI_4K_BYTES = 4096;

  function automatic int unsigned f_beat_bytes(input int unsigned data_w);
    return data_w / 8;
  endfunction

  function automatic logic [2:0] f_arsize(input int unsigned data_w);
    return 3'($clog2(data_w / 8));
  endfunction

  function automatic int unsigned f_beats_4k(input int unsigned data_w);
    return C_AXI_4K_BYTES / (data_w / 8);
  endfunction

  localparam int unsigned C_BEAT_BYTES = f_beat_bytes(512);
  localparam int unsigned C_BEATS_4K   = f_beats_4k(512);

endpackage

// File: rtl/krnl_msm_burst_split.sv
// Burst length for the next INCR burst: limited by remaining beats, max burst
// size and the distance to the next 4 KB page boundary.
module krnl_msm_burst_split
  import krnl_msm_pkg::*;
#(
  parameter int unsigned DATA_W    = 512,
  parameter int unsigned LEN_W     = 32,
  parameter int unsigned MAX_BURST = 64
) (
  input  logic [11:0]      page_addr,
  input  logic [LEN_W-1:0] remaining,
  output logic [8:0]       len
);

  localparam int unsigned ASZ      = $clog2(f_beat_bytes(DATA_W));
  localparam int unsigned BEATS_4K = f_beats_4k(DATA_W);

  logic [11:0] page_beat;
  logic [12:0] to_4k;
  logic [8:0]  cap;

  always_comb begin
    page_beat = page_addr >> ASZ;
    to_4k     = 13'(BEATS_4K) - {1'b0, page_beat};
    cap       = (remaining < LEN_W'(MAX_BURST)) ? 9'(remaining) : 9'(MAX_BURST);
    len       = ({4'b0000, cap} < to_4k) ? cap : to_4k[8:0];
  end

endmodule

// File: rtl/krnl_msm_rd_sched.sv
// AXI4 read-address scheduler: splits a linear fetch into 4 KB-safe bursts,
// bounds bursts in flight, and pulses done once every last R beat is consumed.
//
// state    | meaning
// ST_IDLE  | ready for a command
// ST_ISSUE | presenting bursts on AR, gated by outstanding credit
// ST_DRAIN | all bursts issued, waiting for the remaining last beats
module krnl_msm_rd_sched
  import krnl_msm_pkg::*;
#(
  parameter int unsigned C_AXI_M_ADDR_W    = 64,
  parameter int unsigned C_AXI_M_DATA_W    = 512,
  parameter int unsigned C_LEN_W           = 32,
  parameter int unsigned C_MAX_BURST       = 64,
  parameter int unsigned C_MAX_OUTSTANDING = 16
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst_n,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [C_AXI_M_ADDR_W-1:0] cmd_addr,
  input  logic [C_LEN_W-1:0]        cmd_beats,
  output logic                      busy,
  output logic                      done,
  output logic                      axi_ARVALID,
  input  logic                      axi_ARREADY,
  output logic [C_AXI_M_ADDR_W-1:0] axi_ARADDR,
  output logic [7:0]                axi_ARLEN,
  output logic [2:0]                axi_ARSIZE,
  input  logic                      r_last_hs
);

  localparam int unsigned ASZ = $clog2(f_beat_bytes(C_AXI_M_DATA_W));
  localparam int unsigned OW  = $clog2(C_MAX_OUTSTANDING + 1);
  localparam logic [OW:0] MAX_OUT = (OW + 1)'(C_MAX_OUTSTANDING);
  localparam logic [C_AXI_M_ADDR_W-1:0] BEAT_MASK =
    ~C_AXI_M_ADDR_W'(f_beat_bytes(C_AXI_M_DATA_W) - 1);

  state_e                    state_q, state_d;
  logic [C_AXI_M_ADDR_W-1:0] addr_q, addr_d;
  logic [C_LEN_W-1:0]        rem_q, rem_d;
  logic [OW-1:0]             outst_q, outst_d;
  logic                      arvalid_q, arvalid_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      cmd_ready_q, cmd_ready_d;

  logic [8:0]  len;
  logic        hs, dec;
  logic [OW:0] outst_inc;

  krnl_msm_burst_split #(
    .DATA_W    (C_AXI_M_DATA_W),
    .LEN_W     (C_LEN_W),
    .MAX_BURST (C_MAX_BURST)
  ) u_split (
    .page_addr (addr_q[11:0]),
    .remaining (rem_q),
    .len       (len)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    arvalid_d   = arvalid_q;
    busy_d      = busy_q;
    cmd_ready_d = cmd_ready_q;
    done_d      = 1'b0;
    hs          = arvalid_q & axi_ARREADY;
    dec         = r_last_hs & (outst_q != '0);
    outst_d     = outst_q + OW'(hs) - OW'(dec);
    // Credit looks at the registered count plus our own issue, never at a
    // same-cycle release, so freed credit lands one cycle late.
    outst_inc   = {1'b0, outst_q} + (OW + 1)'(hs);
    case (state_q)
      ST_IDLE: begin
        cmd_ready_d = 1'b1;
        if (cmd_valid && cmd_ready_q) begin
          if (cmd_beats == '0) begin
            done_d = 1'b1;
          end else begin
            addr_d      = cmd_addr & BEAT_MASK;
            rem_d       = cmd_beats;
            busy_d      = 1'b1;
            cmd_ready_d = 1'b0;
            arvalid_d   = {1'b0, outst_q} < MAX_OUT;
            state_d     = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        if (hs) begin
          addr_d = addr_q + (C_AXI_M_ADDR_W'(len) << ASZ);
          rem_d  = rem_q - C_LEN_W'(len);
          if (rem_d == '0) begin
            arvalid_d = 1'b0;
            state_d   = ST_DRAIN;
          end else begin
            arvalid_d = outst_inc < MAX_OUT;
          end
        end else if (!arvalid_q) begin
          arvalid_d = {1'b0, outst_q} < MAX_OUT;
        end
      end
      ST_DRAIN: begin
        if (outst_d == '0) begin
          state_d     = ST_IDLE;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          cmd_ready_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      outst_q     <= '0;
      arvalid_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cmd_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      outst_q     <= outst_d;
      arvalid_q   <= arvalid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign axi_ARVALID = arvalid_q;
  assign axi_ARADDR  = addr_q;
  assign axi_ARLEN   = arvalid_q ? 8'(len - 9'd1) : 8'd0;
  assign axi_ARSIZE  = 3'(ASZ);

endmodule

// File: tb/tb_krnl_msm_rd_sched.sv
// Directed bench for krnl_msm_rd_sched with hand-computed AR sequences.
module tb_krnl_msm_rd_sched;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [63:0] cmd_addr = '0;
  logic [31:0] cmd_beats = '0;
  logic        busy, done;
  logic        axi_ARVALID;
  logic        axi_ARREADY = 1'b0;
  logic [63:0] axi_ARADDR;
  logic [7:0]  axi_ARLEN;
  logic [2:0]  axi_ARSIZE;
  logic        r_last_hs = 1'b0;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  logic [63:0] q_addr[$];
  logic [7:0]  q_len[$];
  int          q_cyc[$];

  krnl_msm_rd_sched dut (
    .ap_clk      (ap_clk),
    .ap_rst_n    (ap_rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_addr    (cmd_addr),
    .cmd_beats   (cmd_beats),
    .busy        (busy),
    .done        (done),
    .axi_ARVALID (axi_ARVALID),
    .axi_ARREADY (axi_ARREADY),
    .axi_ARADDR  (axi_ARADDR),
    .axi_ARLEN   (axi_ARLEN),
    .axi_ARSIZE  (axi_ARSIZE),
    .r_last_hs   (r_last_hs)
  );

  always #5 ap_clk = ~ap_clk;

  always @(posedge ap_clk) cyc <= cyc + 1;

  always @(negedge ap_clk) begin
    if (ap_rst_n && axi_ARVALID && axi_ARREADY) begin
      q_addr.push_back(axi_ARADDR);
      q_len.push_back(axi_ARLEN);
      q_cyc.push_back(cyc);
    end
  end

  task automatic step();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic clear_q();
    q_addr.delete();
    q_len.delete();
    q_cyc.delete();
  endtask

  task automatic issue_cmd(input logic [63:0] a, input logic [31:0] b);
    cmd_addr  = a;
    cmd_beats = b;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic pulse_rlast(input int n);
    for (int i = 0; i < n; i++) begin
      r_last_hs = 1'b1;
      step();
      r_last_hs = 1'b0;
      if (i < n - 1) step();
    end
  endtask

  task automatic wait_done(input string name, input int budget);
    bit seen = 0;
    for (int i = 0; i < budget; i++) begin
      if (done) begin
        seen = 1;
        break;
      end
      step();
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s_done: done not seen within %0d cycles", name, budget);
    end else begin
      n_checks++;
      if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL %s_idle: busy=%b cmd_ready=%b expected 0/1", name, busy, cmd_ready);
      end
    end
    step();
  endtask

  task automatic test_reset();
    ap_rst_n = 1'b0;
    repeat (2) step();
    n_checks++;
    if ({cmd_ready, busy, done, axi_ARVALID} !== 4'b0000 || axi_ARADDR !== 64'h0 || axi_ARLEN !== 8'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: rdy/busy/done/vld=%b addr=%h len=%h expected 0", {cmd_ready, busy, done, axi_ARVALID}, axi_ARADDR, axi_ARLEN);
    end
    n_checks++;
    if (axi_ARSIZE !== 3'd6) begin
      n_fail++;
      $display("FAIL reset_arsize: got %0d expected 6", axi_ARSIZE);
    end
    ap_rst_n = 1'b1;
    step();
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: cmd_ready=%b expected 1", cmd_ready);
    end
  endtask

  task automatic test_single();
    clear_q();
    axi_ARREADY = 1'b1;
    issue_cmd(64'h1000, 32'd1);
    n_checks++;
    if (axi_ARVALID !== 1'b1 || axi_ARADDR !== 64'h1000 || axi_ARLEN !== 8'd0 || axi_ARSIZE !== 3'd6 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_ar: vld=%b addr=%h len=%0d size=%0d busy=%b expected 1/1000/0/6/1", axi_ARVALID, axi_ARADDR, axi_ARLEN, axi_ARSIZE, busy);
    end
    step();
    n_checks++;
    if (axi_ARVALID !== 1'b0 || busy !== 1'b1 || cmd_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL single_drain: vld=%b busy=%b rdy=%b expected 0/1/0", axi_ARVALID, busy, cmd_ready);
    end
    repeat (2) step();
    r_last_hs = 1'b1;
    step();
    r_last_hs = 1'b0;
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL single_done: done=%b busy=%b rdy=%b expected 1/0/1", done, busy, cmd_ready);
    end
    step();
    n_checks++;
    if (done !== 1'b0 || q_addr.size() != 1) begin
      n_fail++;
      $display("FAIL single_pulse: done=%b ars=%0d expected 0/1", done, q_addr.size());
    end
  endtask

  task automatic test_4k_cross();
    clear_q();
    axi_ARREADY = 1'b1;
    issue_cmd(64'h0FC0, 32'd4);
    repeat (8) step();
    n_checks++;
    if (q_addr.size() != 2) begin
      n_fail++;
      $display("FAIL cross_count: got %0d ARs expected 2", q_addr.size());
    end else begin
      n_checks++;
      if (q_addr[0] !== 64'h0FC0 || q_len[0] !== 8'd0 || q_addr[1] !== 64'h1000 || q_len[1] !== 8'd2) begin
        n_fail++;
        $display("FAIL cross_ars: got %h/%0d %h/%0d expected 0fc0/0 1000/2", q_addr[0], q_len[0], q_addr[1], q_len[1]);
      end
    end
    pulse_rlast(2);
    wait_done("cross", 10);
  endtask

  task automatic test_long();
    logic [63:0] ea[4] = '{64'h0, 64'h1000, 64'h2000, 64'h3000};
    logic [7:0]  el[4] = '{8'd63, 8'd63, 8'd63, 8'd7};
    clear_q();
    axi_ARREADY = 1'b1;
    issue_cmd(64'h0, 32'd200);
    repeat (10) step();
    n_checks++;
    if (q_addr.size() != 4) begin
      n_fail++;
      $display("FAIL long_count: got %0d ARs expected 4", q_addr.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (q_addr[i] !== ea[i] || q_len[i] !== el[i] || (i > 0 && q_cyc[i] != q_cyc[i-1] + 1)) begin
          n_fail++;
          $display("FAIL long_ar%0d: got %h/%0d cyc %0d expected %h/%0d consecutive", i, q_addr[i], q_len[i], q_cyc[i], ea[i], el[i]);
        end
      end
    end
    pulse_rlast(4);
    wait_done("long", 10);
  endtask

  task automatic test_credit();
    int rcyc;
    clear_q();
    axi_ARREADY = 1'b1;
    issue_cmd(64'h0, 32'd2048);
    repeat (25) step();
    n_checks++;
    if (q_addr.size() != 16 || axi_ARVALID !== 1'b0) begin
      n_fail++;
      $display("FAIL credit_limit: got %0d ARs vld=%b expected 16/0", q_addr.size(), axi_ARVALID);
    end
    rcyc = cyc;
    r_last_hs = 1'b1;
    step();
    r_last_hs = 1'b0;
    repeat (8) step();
    n_checks++;
    if (q_addr.size() != 17 || axi_ARVALID !== 1'b0) begin
      n_fail++;
      $display("FAIL credit_one: got %0d ARs vld=%b expected 17/0", q_addr.size(), axi_ARVALID);
    end else begin
      n_checks++;
      if (q_cyc[16] != rcyc + 2 || q_addr[16] !== 64'h10000) begin
        n_fail++;
        $display("FAIL credit_timing: AR at cyc %0d addr %h expected cyc %0d addr 10000", q_cyc[16], q_addr[16], rcyc + 2);
      end
    end
    r_last_hs = 1'b1;
    wait_done("credit", 300);
    r_last_hs = 1'b0;
    n_checks++;
    if (q_addr.size() != 32) begin
      n_fail++;
      $display("FAIL credit_total: got %0d ARs expected 32", q_addr.size());
    end
  endtask

  task automatic test_backpressure();
    bit early = 0;
    clear_q();
    axi_ARREADY = 1'b0;
    issue_cmd(64'h2000, 32'd128);
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (axi_ARVALID !== 1'b1 || axi_ARADDR !== 64'h2000 || axi_ARLEN !== 8'd63) begin
        n_fail++;
        $display("FAIL bp_stable%0d: vld=%b addr=%h len=%0d expected 1/2000/63", i, axi_ARVALID, axi_ARADDR, axi_ARLEN);
      end
      step();
    end
    axi_ARREADY = 1'b1;
    step();
    axi_ARREADY = 1'b0;
    step();
    n_checks++;
    if (axi_ARVALID !== 1'b1 || axi_ARADDR !== 64'h3000 || axi_ARLEN !== 8'd63) begin
      n_fail++;
      $display("FAIL bp_second: vld=%b addr=%h len=%0d expected 1/3000/63", axi_ARVALID, axi_ARADDR, axi_ARLEN);
    end
    axi_ARREADY = 1'b1;
    r_last_hs = 1'b1;
    step();
    axi_ARREADY = 1'b0;
    r_last_hs = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (done) early = 1;
      step();
    end
    n_checks++;
    if (early || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_coincident: early done=%b busy=%b expected 0/1", early, busy);
    end
    pulse_rlast(1);
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_done: done=%b expected 1", done);
    end
    step();
  endtask

  task automatic test_zero();
    clear_q();
    axi_ARREADY = 1'b1;
    issue_cmd(64'h5000, 32'd0);
    n_checks++;
    if (done !== 1'b1 || axi_ARVALID !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_done: done=%b vld=%b busy=%b rdy=%b expected 1/0/0/1", done, axi_ARVALID, busy, cmd_ready);
    end
    repeat (3) step();
    n_checks++;
    if (done !== 1'b0 || q_addr.size() != 0) begin
      n_fail++;
      $display("FAIL zero_noar: done=%b ars=%0d expected 0/0", done, q_addr.size());
    end
  endtask

  task automatic test_reset_mid();
    axi_ARREADY = 1'b0;
    issue_cmd(64'h8000, 32'd100);
    n_checks++;
    if (axi_ARVALID !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_pre: vld=%b busy=%b expected 1/1", axi_ARVALID, busy);
    end
    #2 ap_rst_n = 1'b0;
    #1;
    n_checks++;
    if (axi_ARVALID !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || axi_ARLEN !== 8'd0) begin
      n_fail++;
      $display("FAIL rstmid_async: vld=%b busy=%b done=%b len=%0d expected 0/0/0/0", axi_ARVALID, busy, done, axi_ARLEN);
    end
    step();
    ap_rst_n = 1'b1;
    step();
    clear_q();
    axi_ARREADY = 1'b1;
    issue_cmd(64'h0, 32'd1);
    n_checks++;
    if (axi_ARVALID !== 1'b1 || axi_ARADDR !== 64'h0 || axi_ARLEN !== 8'd0) begin
      n_fail++;
      $display("FAIL rstmid_restart: vld=%b addr=%h len=%0d expected 1/0/0", axi_ARVALID, axi_ARADDR, axi_ARLEN);
    end
    step();
    pulse_rlast(1);
    wait_done("rstmid", 5);
  endtask

  initial begin
    test_reset();
    test_single();
    test_4k_cross();
    test_long();
    test_credit();
    test_backpressure();
    test_zero();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
